itch_msg_framer: RTL and testbench

- Sits directly downstream of the AXI4-Stream byte adapter and consumes its byte stream (8-bit byte plus valid; no backpressure).
- Delimits ITCH 5.0 messages carried with a 2-byte big-endian length prefix, as in SoupBinTCP/MoldUDP64 payloads.
- Emits one registered byte per cycle, tagged with start/end-of-message, byte index, message type, declared length and length-check status. The field-extraction parser consumes these tags.

---
 rtl/itch_pkg.sv | 40 ++++
 rtl/itch_len_lookup.sv | 14 +
 rtl/itch_msg_framer.sv | 169 ++++++++++++++++
 tb/tb_itch_msg_framer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// Shared ITCH 5.0 definitions: framer FSM states, message type codes and
// the fixed body length for each known message type.
package itch_pkg;

  typedef enum logic [1:0] {
    LEN_HI = 2'd0,
    LEN_LO = 2'd1,
    BODY   = 2'd2,
    SKIP   = 2'd3
  } itch_state_e;

  localparam logic [7:0] ITCH_SYS_EVENT   = 8'h53;
  localparam logic [7:0] ITCH_STOCK_DIR   = 8'h52;
  localparam logic [7:0] ITCH_ADD_ORDER   = 8'h41;
  localparam logic [7:0] ITCH_ADD_MPID    = 8'h46;
  localparam logic [7:0] ITCH_EXECUTED    = 8'h45;
  localparam logic [7:0] ITCH_EXEC_PRICE  = 8'h43;
  localparam logic [7:0] ITCH_CANCEL      = 8'h58;
  localparam logic [7:0] ITCH_DELETE      = 8'h44;
  localparam logic [7:0] ITCH_REPLACE     = 8'h55;
  localparam logic [7:0] ITCH_TRADE       = 8'h50;

  // A return of 0 marks the type as unknown; no ITCH message has an empty body.
  function automatic logic [15:0] itch_expected_len(input logic [7:0] msg_type);
    case (msg_type)
      ITCH_SYS_EVENT:  return 16'd12;
      ITCH_STOCK_DIR:  return 16'd39;
      ITCH_ADD_ORDER:  return 16'd36;
      ITCH_ADD_MPID:   return 16'd40;
      ITCH_EXECUTED:   return 16'd31;
      ITCH_EXEC_PRICE: return 16'd36;
      ITCH_CANCEL:     return 16'd23;
      ITCH_DELETE:     return 16'd19;
      ITCH_REPLACE:    return 16'd35;
      ITCH_TRADE:      return 16'd44;
      default:         return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/itch_len_lookup.sv
// Combinational ITCH type decoder: reports whether a type byte is known and
// the body length that type must carry.
import itch_pkg::*;

module itch_len_lookup (
  input  logic [7:0]  i_type,
  output logic        o_known,
  output logic [15:0] o_expected_len
);

  assign o_expected_len = itch_expected_len(i_type);
  assign o_known        = (o_expected_len != 16'd0);

endmodule

// File: rtl/itch_msg_framer.sv
// Splits a length-prefixed ITCH byte stream into tagged message body bytes.
// Optional statistics counters are enabled with ITCH_FRAMER_STATS_EN.
import itch_pkg::*;

module itch_msg_framer #(
  parameter int MAX_MSG_LEN = 64,
  parameter int IDX_W       = $clog2(MAX_MSG_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  output logic             out_sop,
  output logic             out_eop,
  output logic [IDX_W-1:0] out_idx,
  output logic [7:0]       out_msg_type,
  output logic [15:0]      out_msg_len,
  output logic             out_len_err,
  output logic             out_unk_type,
  output logic             drop_pulse,
  output logic [31:0]      msg_count,
  output logic [31:0]      err_count
);

  itch_state_e      r_state;
  logic [7:0]       r_len_hi;
  logic [15:0]      r_len;
  logic [15:0]      r_remaining;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_type;
  logic             r_len_err;
  logic             r_unk_type;

  logic [15:0]      w_len;
  logic             w_known;
  logic [15:0]      w_exp_len;
  logic             w_sop_len_err;
  logic             w_is_sop;
  logic             w_is_eop;
  logic             w_oversize;

  assign w_len      = {r_len_hi, in_byte};
  assign w_oversize = (w_len > 16'(MAX_MSG_LEN));
  assign w_is_sop   = (r_idx == '0);
  assign w_is_eop   = (r_remaining == 16'd1);

  // The lookup sees the live byte so type tags are valid on the sop byte itself.
  itch_len_lookup u_len_lookup (
    .i_type         (in_byte),
    .o_known        (w_known),
    .o_expected_len (w_exp_len)
  );

  assign w_sop_len_err = w_known && (w_exp_len != r_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LEN_HI;
      r_len_hi     <= '0;
      r_len        <= '0;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_type       <= '0;
      r_len_err    <= 1'b0;
      r_unk_type   <= 1'b0;
      out_byte     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_idx      <= '0;
      out_msg_type <= '0;
      out_msg_len  <= '0;
      out_len_err  <= 1'b0;
      out_unk_type <= 1'b0;
      drop_pulse   <= 1'b0;
    end else begin
      out_byte     <= '0;
      out_valid    <= 1'b0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      out_idx      <= '0;
      out_msg_type <= '0;
      out_msg_len  <= '0;
      out_len_err  <= 1'b0;
      out_unk_type <= 1'b0;
      drop_pulse   <= 1'b0;
      if (in_valid) begin
        case (r_state)
          LEN_HI: begin
            r_len_hi <= in_byte;
            r_state  <= LEN_LO;
          end
          LEN_LO: begin
            if (w_len == 16'd0) begin
              r_state <= LEN_HI;
            end else if (w_oversize) begin
              drop_pulse  <= 1'b1;
              r_remaining <= w_len;
              r_state     <= SKIP;
            end else begin
              r_len       <= w_len;
              r_remaining <= w_len;
              r_idx       <= '0;
              r_state     <= BODY;
            end
          end
          BODY: begin
            out_valid    <= 1'b1;
            out_byte     <= in_byte;
            out_idx      <= r_idx;
            out_sop      <= w_is_sop;
            out_eop      <= w_is_eop;
            out_msg_len  <= r_len;
            out_msg_type <= w_is_sop ? in_byte : r_type;
            out_len_err  <= w_is_sop ? w_sop_len_err : r_len_err;
            out_unk_type <= w_is_sop ? !w_known : r_unk_type;
            if (w_is_sop) begin
              r_type     <= in_byte;
              r_len_err  <= w_sop_len_err;
              r_unk_type <= !w_known;
            end
            r_remaining <= r_remaining - 16'd1;
            if (w_is_eop) begin
              r_state <= LEN_HI;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          SKIP: begin
            r_remaining <= r_remaining - 16'd1;
            if (w_is_eop) r_state <= LEN_HI;
          end
          default: r_state <= LEN_HI;
        endcase
      end
    end
  end

`ifdef ITCH_FRAMER_STATS_EN
  logic [31:0] r_msg_count;
  logic [31:0] r_err_count;
  logic        w_eop_evt;
  logic        w_drop_evt;
  logic        w_msg_err;

  assign w_eop_evt  = in_valid && (r_state == BODY) && w_is_eop;
  assign w_drop_evt = in_valid && (r_state == LEN_LO) && w_oversize;
  assign w_msg_err  = w_is_sop ? (w_sop_len_err || !w_known) : (r_len_err || r_unk_type);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_msg_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_eop_evt) r_msg_count <= r_msg_count + 32'd1;
      if ((w_eop_evt && w_msg_err) || w_drop_evt) r_err_count <= r_err_count + 32'd1;
    end
  end

  assign msg_count = r_msg_count;
  assign err_count = r_err_count;
`else
  assign msg_count = 32'd0;
  assign err_count = 32'd0;
`endif

endmodule

// File: tb/tb_itch_msg_framer.sv
// Self-checking bench for itch_msg_framer: frames are built at message level,
// expanded into an expected per-input-byte output record stream and compared.
module tb_itch_msg_framer;

  localparam int MAX = 64;
  localparam int IW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [IW-1:0] out_idx;
  logic [7:0]    out_msg_type;
  logic [15:0]   out_msg_len;
  logic          out_len_err;
  logic          out_unk_type;
  logic          drop_pulse;
  logic [31:0]   msg_count;
  logic [31:0]   err_count;

  always #5 clk = ~clk;

  itch_msg_framer #(.MAX_MSG_LEN(MAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_idx      (out_idx),
    .out_msg_type (out_msg_type),
    .out_msg_len  (out_msg_len),
    .out_len_err  (out_len_err),
    .out_unk_type (out_unk_type),
    .drop_pulse   (drop_pulse),
    .msg_count    (msg_count),
    .err_count    (err_count)
  );

  // {drop, valid, byte, sop, eop, idx, type, len, len_err, unk}
  typedef logic [43:0] rec_t;

  logic [7:0] q_in[$];
  rec_t       q_exp[$];
  int checks = 0;
  int errors = 0;
  int m_msgs = 0;
  int m_errs = 0;
  logic [7:0] known_types [10] = '{8'h53, 8'h52, 8'h41, 8'h46, 8'h45,
                                  8'h43, 8'h58, 8'h44, 8'h55, 8'h50};

  function automatic int ref_len(input logic [7:0] t);
    case (t)
      8'h53: return 12;
      8'h52: return 39;
      8'h41: return 36;
      8'h46: return 40;
      8'h45: return 31;
      8'h43: return 36;
      8'h58: return 23;
      8'h44: return 19;
      8'h55: return 35;
      8'h50: return 44;
      default: return 0;
    endcase
  endfunction

  function automatic rec_t mk(input bit drop, input bit valid, input logic [7:0] b,
                              input bit sop, input bit eop, input int idx,
                              input logic [7:0] t, input int len, input bit le, input bit uk);
    return {drop, valid, b, sop, eop, IW'(idx), t, 16'(len), le, uk};
  endfunction

  function automatic rec_t obs();
    return {drop_pulse, out_valid, out_byte, out_sop, out_eop, out_idx,
            out_msg_type, out_msg_len, out_len_err, out_unk_type};
  endfunction

  task automatic check(input string tag, input rec_t exp);
    rec_t o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic check_stats(input string tag);
    checks++;
`ifdef ITCH_FRAMER_STATS_EN
    assert (msg_count === 32'(m_msgs)) else begin
      errors++;
      $error("FAIL %s_msg_count observed=%0d expected=%0d", tag, msg_count, m_msgs);
    end
    checks++;
    assert (err_count === 32'(m_errs)) else begin
      errors++;
      $error("FAIL %s_err_count observed=%0d expected=%0d", tag, err_count, m_errs);
    end
`else
    assert (msg_count === 32'd0) else begin
      errors++;
      $error("FAIL %s_msg_count observed=%0d expected=0", tag, msg_count);
    end
    checks++;
    assert (err_count === 32'd0) else begin
      errors++;
      $error("FAIL %s_err_count observed=%0d expected=0", tag, err_count);
    end
`endif
  endtask

  // Queue a frame of declared length L with type byte t; only n_body body bytes are sent.
  task automatic add_frame(input int L, input logic [7:0] t, input int n_body);
    logic [15:0] l16;
    int el;
    bit le, uk;
    l16 = 16'(L);
    q_in.push_back(l16[15:8]);
    q_exp.push_back('0);
    q_in.push_back(l16[7:0]);
    q_exp.push_back(mk(L > MAX, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0));
    if (L > MAX) begin
      for (int k = 0; k < L; k++) begin
        q_in.push_back(8'($urandom));
        q_exp.push_back('0);
      end
      m_errs++;
    end else if (L > 0) begin
      el = ref_len(t);
      uk = (el == 0);
      le = !uk && (el != L);
      for (int k = 0; k < n_body; k++) begin
        logic [7:0] b;
        b = (k == 0) ? t : 8'($urandom);
        q_in.push_back(b);
        q_exp.push_back(mk(0, 1, b, k == 0, k == L - 1, k, t, L, le, uk));
      end
      if (n_body == L) begin
        m_msgs++;
        if (le || uk) m_errs++;
      end
    end
  endtask

  // gap_mode: 0 back-to-back, 1 idle after every byte, 2 random idles.
  task automatic run(input int gap_mode, input string tag);
    int gaps;
    while (q_in.size() > 0) begin
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        @(posedge clk); #1;
        check({tag, "_idle"}, '0);
      end
      in_valid = 1'b1;
      in_byte  = q_in.pop_front();
      @(posedge clk); #1;
      check(tag, q_exp.pop_front());
    end
    in_valid = 1'b0;
    in_byte  = 8'h00;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset", '0);
    check_stats("reset");
    rst = 1'b0;

    add_frame(36, 8'h41, 36);
    run(0, "add_order");
    check_stats("add_order");

    add_frame(0, 8'h00, 0);
    add_frame(12, 8'h53, 12);
    run(0, "zero_then_s");

    add_frame(200, 8'h00, 0);
    add_frame(23, 8'h58, 23);
    run(0, "drop_then_x");
    check_stats("drop_then_x");

    add_frame(20, 8'h44, 20);
    add_frame(5, 8'h7A, 5);
    run(0, "len_err_unk");
    check_stats("len_err_unk");

    add_frame(36, 8'h41, 36);
    run(1, "gapped");

    add_frame(64, 8'h41, 64);
    add_frame(65, 8'h00, 0);
    add_frame(1, 8'h99, 1);
    run(0, "bounds");
    check_stats("bounds");

    add_frame(36, 8'h41, 10);
    run(0, "pre_rst");
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst", '0);
    rst = 1'b0;
    m_msgs = 0;
    m_errs = 0;
    check_stats("mid_rst");
    add_frame(1, 8'h53, 1);
    run(0, "post_rst");
    check_stats("post_rst");

    for (int f = 0; f < 40; f++) begin
      int kind, L;
      logic [7:0] t;
      kind = int'($urandom_range(0, 9));
      t = known_types[$urandom_range(0, 9)];
      if (kind == 0) begin
        L = 0;
      end else if (kind == 1) begin
        L = int'($urandom_range(MAX + 1, 200));
      end else if (kind == 2) begin
        L = int'($urandom_range(1, MAX));
        t = 8'($urandom);
      end else if (kind >= 8) begin
        L = int'($urandom_range(1, MAX));
      end else begin
        L = ref_len(t);
      end
      add_frame(L, t, (L > MAX) ? 0 : L);
    end
    run(2, "random");
    check_stats("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
